// File: rtl/crom_arbiter.sv
// crom_arbiter
// Shares one synchronous character ROM between NOF_REQ renderers. Requests
// are captured on pixel-enable cycles into per-requester pending flags and
// address latches, then served round-robin, one ROM access at a time.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   en                block enable (en=0 behaves exactly like reset)
//   clk_en_pixel      pixel clock enable
//   rq, addr          per-requester request level and flattened addresses
//   rom_addr, rom_en  registered ROM address / one-clk read strobe
//   rom_dout          ROM read data, valid ROM_LATENCY clks after rom_en
//   dout, dout_valid  flattened held read data and per-requester update pulse
//   overrun           sticky: a request arrived while the previous one was pending
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no access in flight; grant the next pending requester
// S_WAIT    | ROM read issued, counting down the ROM latency
// S_CAPTURE | rom_dout valid; store it for the granted requester
module crom_arbiter #(
  parameter int NOF_REQ     = 4,
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_W      = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clk_en_pixel,
  input  logic [NOF_REQ-1:0]        rq,
  input  logic [NOF_REQ*ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [7:0]                rom_dout,
  output logic [NOF_REQ*8-1:0]      dout,
  output logic [NOF_REQ-1:0]        dout_valid,
  output logic                      overrun
);

  localparam int PTR_W = $clog2(NOF_REQ);
  localparam int CNT_W = $clog2(ROM_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic                  clr;
  logic [NOF_REQ-1:0]    pending;
  logic [NOF_REQ-1:0]    cap;
  logic [ADDR_W-1:0]     addr_q [NOF_REQ];
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      gnt_q;
  logic [PTR_W:0]        search_idx;
  logic                  gnt_found;
  logic [CNT_W-1:0]      lat_cnt;
  logic                  grant_fire;
  logic                  capture_fire;

  assign clr = reset | ~en;
  assign cap = rq & {NOF_REQ{clk_en_pixel}};

  // Round-robin search starting at rr_ptr. The index is one bit wider than
  // rr_ptr so the wrap works for non-power-of-2 NOF_REQ.
  always_comb begin
    gnt_idx    = '0;
    gnt_found  = 1'b0;
    search_idx = '0;
    for (int k = 0; k < NOF_REQ; k++) begin
      search_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (search_idx >= (PTR_W+1)'(NOF_REQ))
        search_idx = search_idx - (PTR_W+1)'(NOF_REQ);
      if (!gnt_found && (search_idx < (PTR_W+1)'(NOF_REQ)) &&
          pending[search_idx[PTR_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = search_idx[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    if (gnt_found) state_nxt = S_WAIT;
      S_WAIT:    state_nxt = (lat_cnt == CNT_W'(1)) ? S_CAPTURE : S_WAIT;
      S_CAPTURE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant_fire   = 1'b0;
    capture_fire = 1'b0;
    case (state)
      S_IDLE:    grant_fire   = gnt_found;
      S_CAPTURE: capture_fire = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pending    <= '0;
      rr_ptr     <= '0;
      gnt_q      <= '0;
      lat_cnt    <= '0;
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      dout       <= '0;
      dout_valid <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < NOF_REQ; i++) addr_q[i] <= '0;
    end else begin
      rom_en     <= grant_fire;
      dout_valid <= '0;

      if (grant_fire) begin
        gnt_q            <= gnt_idx;
        rom_addr         <= addr_q[gnt_idx];
        lat_cnt          <= CNT_W'(ROM_LATENCY);
        pending[gnt_idx] <= 1'b0;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end

      if (capture_fire) begin
        dout[gnt_q*8 +: 8] <= rom_dout;
        dout_valid[gnt_q]  <= 1'b1;
        rr_ptr             <= (gnt_q == PTR_W'(NOF_REQ-1)) ? '0 : gnt_q + 1'b1;
      end

      // Capture comes after the grant clear so a same-clk re-request keeps
      // pending set; the grant above already used the old address.
      for (int i = 0; i < NOF_REQ; i++) begin
        if (cap[i]) begin
          if (pending[i] && !(grant_fire && (gnt_idx == PTR_W'(i))))
            overrun <= 1'b1;
          pending[i] <= 1'b1;
          addr_q[i]  <= addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_crom_arbiter.sv
// Testbench for crom_arbiter: directed vectors from a table, hand-written
// multi-cycle sequences, and randomized traffic checked every clk against a
// transaction-level reference model.
module tb_crom_arbiter;

  localparam int N  = 4;
  localparam int L  = 1;
  localparam int AW = 11;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic            clk_en_pixel;
  logic [N-1:0]    rq;
  logic [N*AW-1:0] addr;
  logic [AW-1:0]   rom_addr;
  logic            rom_en;
  logic [7:0]      rom_dout;
  logic [N*8-1:0]  dout;
  logic [N-1:0]    dout_valid;
  logic            overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  crom_arbiter #(.NOF_REQ(N), .ROM_LATENCY(L), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clk_en_pixel (clk_en_pixel),
    .rq           (rq),
    .addr         (addr),
    .rom_addr     (rom_addr),
    .rom_en       (rom_en),
    .rom_dout     (rom_dout),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .overrun      (overrun)
  );

  // Synchronous ROM: content byte = address[7:0], L clks of latency.
  logic [7:0] rom_pipe [L];
  always_ff @(posedge clk) begin
    rom_pipe[0] <= rom_addr[7:0];
    for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_dout = rom_pipe[L-1];

  // ---------------- reference model ----------------
  int            cyc = 0;
  logic [N-1:0]  m_pend;
  logic [AW-1:0] m_paddr [N];
  int            m_rr, m_free_at, m_cap_at, m_cap_g;
  logic [7:0]    m_cap_data;
  logic          m_rom_en;
  logic [AW-1:0] m_rom_addr;
  logic [7:0]    m_dout [N];
  logic [N-1:0]  m_dv;
  logic          m_ovr;

  // logs of actual DUT activity for the directed sequences
  logic [AW-1:0] q_addr [$];
  int            q_cyc  [$];
  int            dv_cnt [N];
  int            dv_last;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_pend = '0; m_rr = 0; m_free_at = 0; m_cap_at = -1; m_cap_g = 0;
    m_cap_data = '0; m_rom_en = 1'b0; m_rom_addr = '0; m_dv = '0; m_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin m_dout[i] = '0; m_paddr[i] = '0; end
  endtask

  // One arbitration slot lasts L+2 clks; the grant happens on the first
  // clk at or after the slot frees up with something pending.
  task automatic model_edge();
    int g;
    cyc++;
    if (reset || !en) begin
      model_reset();
      return;
    end
    m_dv = '0;
    m_rom_en = 1'b0;
    if (cyc == m_cap_at) begin
      m_dout[m_cap_g] = m_cap_data;
      m_dv[m_cap_g] = 1'b1;
      m_cap_at = -1;
    end
    g = -1;
    if (cyc >= m_free_at) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      end
    end
    if (g >= 0) begin
      m_rom_en = 1'b1;
      m_rom_addr = m_paddr[g];
      m_cap_data = m_paddr[g][7:0];
      m_cap_g = g;
      m_cap_at = cyc + L + 1;
      m_free_at = cyc + L + 2;
      m_rr = (g + 1) % N;
      m_pend[g] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (clk_en_pixel && rq[i]) begin
        if (m_pend[i]) m_ovr = 1'b1;
        m_pend[i] = 1'b1;
        m_paddr[i] = addr[i*AW +: AW];
      end
    end
  endtask

  task automatic compare();
    logic [N*8-1:0] md;
    for (int i = 0; i < N; i++) md[i*8 +: 8] = m_dout[i];
    check("rom_en", rom_en, m_rom_en);
    check("rom_addr", rom_addr, m_rom_addr);
    check("dout_valid", dout_valid, m_dv);
    check("dout", dout, md);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    if (rom_en) begin q_addr.push_back(rom_addr); q_cyc.push_back(cyc); end
    for (int i = 0; i < N; i++) if (dout_valid[i]) begin dv_cnt[i]++; dv_last = cyc; end
  endtask

  task automatic clear_logs();
    q_addr.delete(); q_cyc.delete(); dv_last = 0;
    for (int i = 0; i < N; i++) dv_cnt[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; rq = '0; clk_en_pixel = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // One pixel period: rq/addr held for 'per' clks, pixel enable on the first.
  task automatic pix(input logic [N-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [AW-1:0] a2, input logic [AW-1:0] a3, input int per);
    rq = r; addr = {a3, a2, a1, a0}; clk_en_pixel = 1'b1;
    step();
    clk_en_pixel = 1'b0;
    for (int k = 1; k < per; k++) step();
  endtask

  task automatic check_order(input string nm, input logic [AW-1:0] e0, input logic [AW-1:0] e1,
                             input logic [AW-1:0] e2, input logic [AW-1:0] e3);
    logic [AW-1:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({nm, "_count"}, q_addr.size(), 4);
    for (int k = 0; k < 4; k++)
      check({nm, "_addr"}, (q_addr.size() > k) ? q_addr[k] : '1, e[k]);
    for (int k = 0; k < 3; k++)
      check({nm, "_spacing"}, (q_cyc.size() > k+1) ? q_cyc[k+1] - q_cyc[k] : 0, L + 2);
  endtask

  typedef struct {
    int            req;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } vec_t;
  vec_t vecs [4];

  initial begin
    logic [N*8-1:0] ed;
    int             per;
    int             cap_c;
    logic           saw_b1;
    logic [AW-1:0]  last0;

    vecs[0] = '{2, 11'h208, 8'h08};
    vecs[1] = '{0, 11'h7FF, 8'hFF};
    vecs[2] = '{3, 11'h155, 8'h55};
    vecs[3] = '{1, 11'h0A3, 8'hA3};

    reset = 1'b1; en = 1'b1; clk_en_pixel = 1'b0; rq = '0; addr = '0;
    model_reset();
    clear_logs();
    step();
    step();
    check("reset_rom_en", rom_en, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_dout", dout, 0);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_overrun", overrun, 0);
    reset = 1'b0;

    // single-request latency vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      addr = '0;
      addr[vecs[v].req*AW +: AW] = vecs[v].a;
      rq = '0;
      rq[vecs[v].req] = 1'b1;
      clk_en_pixel = 1'b1;
      step();
      clk_en_pixel = 1'b0;
      check("vec_rom_en_early", rom_en, 0);
      step();
      check("vec_rom_en", rom_en, 1);
      check("vec_rom_addr", rom_addr, vecs[v].a);
      step();
      check("vec_rom_en_drop", rom_en, 0);
      check("vec_dv_early", dout_valid, 0);
      step();
      ed = '0;
      ed[vecs[v].req*8 +: 8] = vecs[v].d;
      check("vec_dout_valid", dout_valid, 4'b0001 << vecs[v].req);
      check("vec_dout", dout, ed);
      rq = '0;
      step();
      check("vec_rom_addr_hold", rom_addr, vecs[v].a);
    end

    // all four at once, from rr_ptr = 0
    do_reset();
    clear_logs();
    pix(4'hF, 11'h001, 11'h002, 11'h003, 11'h004, 1);
    cap_c = cyc;
    rq = '0;
    for (int k = 0; k < 15; k++) step();
    check_order("all4", 11'h001, 11'h002, 11'h003, 11'h004);
    check("all4_dv_within_13", (dv_last - cap_c) <= 13, 1);
    for (int i = 0; i < N; i++) check("all4_dv_count", dv_cnt[i], 1);

    // fairness: prime rr_ptr to 2 via requester 1
    pix(4'b0010, 11'h000, 11'h011, 11'h000, 11'h000, 5);
    clear_logs();
    pix(4'hF, 11'h021, 11'h022, 11'h023, 11'h024, 16);
    check_order("fair", 11'h023, 11'h024, 11'h021, 11'h022);

    // overrun: requester 3 occupies the ROM while rq[0] re-requests
    do_reset();
    pix(4'b0001, 11'h030, 11'h000, 11'h000, 11'h000, 4);
    clear_logs();
    check("ovr_before", overrun, 0);
    pix(4'b1001, 11'h041, 11'h000, 11'h000, 11'h03A, 2);
    pix(4'b1001, 11'h042, 11'h000, 11'h000, 11'h03A, 2);
    pix(4'b1001, 11'h043, 11'h000, 11'h000, 11'h03A, 2);
    rq = '0;
    for (int k = 0; k < 20; k++) step();
    check("ovr_flag", overrun, 1);
    saw_b1 = 1'b0;
    last0 = '0;
    foreach (q_addr[k]) begin
      if (q_addr[k] == 11'h041) saw_b1 = 1'b1;
      if (q_addr[k][AW-1:4] == 7'h04) last0 = q_addr[k];
    end
    check("ovr_stale_served", saw_b1, 0);
    check("ovr_last_served", last0, 11'h043);

    // reset and en=0 in the middle of an access
    for (int t = 0; t < 2; t++) begin
      do_reset();
      pix(4'b0100, 11'h000, 11'h000, 11'h2AA, 11'h000, 1);
      rq = '0;
      step();
      check("abort_rom_en", rom_en, 1);
      if (t == 0) reset = 1'b1; else en = 1'b0;
      step();
      check("abort_rom_en_cleared", rom_en, 0);
      check("abort_rom_addr_cleared", rom_addr, 0);
      check("abort_dout_cleared", dout, 0);
      check("abort_dv_cleared", dout_valid, 0);
      reset = 1'b0; en = 1'b1;
      clear_logs();
      for (int k = 0; k < 6; k++) step();
      check("abort_no_dv", dv_cnt[2], 0);
    end

    // rq[1] held across three pixel enables
    do_reset();
    clear_logs();
    for (int k = 0; k < 3; k++) pix(4'b0010, 11'h000, 11'h1C3, 11'h000, 11'h000, 6);
    rq = '0;
    for (int k = 0; k < 6; k++) step();
    check("held_accesses", q_addr.size(), 3);
    check("held_dv_pulses", dv_cnt[1], 3);
    check("held_dout", dout[15:8], 8'hC3);

    // randomized traffic, alternating well-behaved and overloaded pixel rates
    for (int blk = 0; blk < 6; blk++) begin
      per = (blk % 2 == 0) ? 13 + $urandom_range(0, 3) : 2 + $urandom_range(0, 1);
      for (int c = 0; c < 400; c++) begin
        if (c % per == 0) begin
          clk_en_pixel = 1'b1;
          rq = N'($urandom());
          addr = (N*AW)'({$urandom(), $urandom()});
        end else begin
          clk_en_pixel = 1'b0;
        end
        reset = ($urandom_range(0, 199) == 0);
        en = ($urandom_range(0, 199) != 0);
        step();
      end
    end
    reset = 1'b0; en = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
